// File: rtl/ddr_pkg.sv
// Shared button/direction definitions for the button conditioner
// and the VGA game controller.
package ddr_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam int BTN_RST_IDX = 4;
  localparam int NUM_BTN     = 5;
  localparam int NUM_DIR     = 4;

  typedef enum logic {
    EVT_IDLE,
    EVT_VALID
  } evt_state_t;

  // Lowest direction code wins: up > right > down > left.
  function automatic dir_t pick_dir(input logic [NUM_DIR-1:0] pend);
    dir_t d;
    priority case (1'b1)
      pend[0]: d = DIR_UP;
      pend[1]: d = DIR_RIGHT;
      pend[2]: d = DIR_DOWN;
      default: d = DIR_LEFT;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Direction event handshake between the button conditioner
// and the game controller.
interface btn_conditioner_if;
  import ddr_pkg::*;

  logic o_evt_valid;
  dir_t o_evt_code;
  logic i_evt_ack;

  modport master (
    output o_evt_valid,
    output o_evt_code,
    input  i_evt_ack
  );

  modport slave (
    input  o_evt_valid,
    input  o_evt_code,
    output i_evt_ack
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter,
// registered clean level and rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level <= stable;
      press <= stable & ~level;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Board button conditioner: per-button debounce plus a
// pending/priority arbiter presenting one direction event at a time.
module btn_conditioner
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic               o_overflow,
  btn_conditioner_if.master  evt
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (i_clk),
      .rst  (i_rst),
      .raw  (i_btn_raw[i]),
      .level(o_level[i]),
      .press(o_press[i])
    );
  end

  logic [NUM_DIR-1:0] arrow;
  logic [NUM_DIR-1:0] pend;
  logic [NUM_DIR-1:0] clr;
  evt_state_t         state;

  // The rst button is only reported through o_level/o_press.
  assign arrow = o_press[NUM_DIR-1:0];

  always_comb begin
    clr = '0;
    if (state == EVT_IDLE && pend != '0) begin
      clr[pick_dir(pend)] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= EVT_IDLE;
      pend            <= '0;
      o_overflow      <= 1'b0;
      evt.o_evt_valid <= 1'b0;
      evt.o_evt_code  <= DIR_UP;
    end else begin
      // A press landing on the bit being loaded is kept, not merged.
      pend <= (pend & ~clr) | arrow;
      if (|(arrow & pend & ~clr)) begin
        o_overflow <= 1'b1;
      end
      unique case (state)
        EVT_IDLE: begin
          if (pend != '0) begin
            evt.o_evt_code  <= pick_dir(pend);
            evt.o_evt_valid <= 1'b1;
            state           <= EVT_VALID;
          end
        end
        EVT_VALID: begin
          if (evt.i_evt_ack) begin
            evt.o_evt_valid <= 1'b0;
            state           <= EVT_IDLE;
          end
        end
        default: state <= EVT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomized bench for btn_conditioner against a
// window-based behavioural model of debounce and event delivery.
module tb_btn_conditioner;
  import ddr_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raw;
  logic       ack;
  logic [4:0] level;
  logic [4:0] press;
  logic       overflow;

  always #5 clk = ~clk;

  btn_conditioner_if evt ();
  assign evt.i_evt_ack = ack;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn_raw (raw),
    .o_level   (level),
    .o_press   (press),
    .o_overflow(overflow),
    .evt       (evt)
  );

  int passed = 0;
  int total  = 0;

  // Model: a button's accepted value flips once the last D
  // synchronised samples all disagree with it.
  logic [4:0]   m_s1, m_s2, m_acc, m_lvl, m_prs;
  logic [D-1:0] m_win [5];
  logic [3:0]   m_pend;
  logic         m_valid;
  dir_t         m_code;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic [4:0] nl, np;
    logic [3:0] taken;
    int         pick;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_lvl = '0; m_prs = '0;
      for (int b = 0; b < 5; b++) m_win[b] = '0;
      m_pend = '0; m_valid = 1'b0; m_code = DIR_UP; m_ovf = 1'b0;
    end else begin
      taken = '0;
      if (!m_valid) begin
        pick = -1;
        for (int d = 0; d < 4; d++)
          if (pick < 0 && m_pend[d]) pick = d;
        if (pick >= 0) begin
          m_valid = 1'b1;
          m_code = dir_t'(pick);
          taken[pick] = 1'b1;
        end
      end else if (ack) begin
        m_valid = 1'b0;
      end
      for (int d = 0; d < 4; d++) begin
        if (m_prs[d] && m_pend[d] && !taken[d]) m_ovf = 1'b1;
        m_pend[d] = (m_pend[d] && !taken[d]) || m_prs[d];
      end
      nl = m_acc;
      np = m_acc & ~m_lvl;
      for (int b = 0; b < 5; b++) begin
        m_win[b] = {m_win[b][D-2:0], m_s2[b]};
        if (m_win[b] == {D{~m_acc[b]}}) m_acc[b] = ~m_acc[b];
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_lvl = nl;
      m_prs = np;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("level", level, m_lvl);
    chk("press", press, m_prs);
    chk("valid", evt.o_evt_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    if (m_valid) chk("code", evt.o_evt_code, m_code);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!evt.o_evt_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid", evt.o_evt_valid, 1);
  endtask

  initial begin
    int   cnt_a, cnt_b;
    dir_t exp3 [3];
    exp3[0] = DIR_UP; exp3[1] = DIR_DOWN; exp3[2] = DIR_LEFT;

    rst = 1'b1; raw = '0; ack = 1'b0;
    tick();
    chk("reset_outs", {level, press, evt.o_evt_valid, overflow}, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Debounce latency
    raw[0] = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i == 5) chk("t1_level_early", level[0], 0);
      if (i == 6) begin
        chk("t1_level", level[0], 1);
        chk("t1_press", press[0], 1);
      end
      if (i == 7) chk("t1_press_one", press[0], 0);
      if (i == 8) begin
        chk("t1_valid", evt.o_evt_valid, 1);
        chk("t1_code", evt.o_evt_code, DIR_UP);
      end
    end
    ack = 1'b1; tick(); ack = 1'b0;
    raw[0] = 1'b0;
    repeat (10) tick();

    // Glitch
    raw[1] = 1'b1;
    repeat (3) tick();
    raw[1] = 1'b0;
    repeat (10) begin
      tick();
      chk("t2_quiet", {level[1], press[1], evt.o_evt_valid}, 0);
    end

    // Simultaneous presses
    raw = 5'b01101;
    for (int k = 0; k < 3; k++) begin
      wait_valid(20);
      chk("t3_code", evt.o_evt_code, exp3[k]);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("t3_bubble", evt.o_evt_valid, 0);
      tick();
      chk("t3_next", evt.o_evt_valid, (k < 2) ? 1 : 0);
    end
    raw = '0;
    repeat (10) tick();

    // Backpressure and overflow
    raw[3] = 1'b1;
    wait_valid(20);
    chk("t4_code", evt.o_evt_code, DIR_LEFT);
    raw[3] = 1'b0; repeat (10) tick();
    raw[3] = 1'b1; repeat (10) tick();
    chk("t4_no_ovf", overflow, 0);
    chk("t4_held", evt.o_evt_valid, 1);
    raw[3] = 1'b0; repeat (10) tick();
    raw[3] = 1'b1; repeat (10) tick();
    chk("t4_ovf", overflow, 1);
    raw[3] = 1'b0; repeat (10) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    wait_valid(5);
    chk("t4_again", evt.o_evt_code, DIR_LEFT);
    ack = 1'b1; tick(); ack = 1'b0;
    cnt_a = 0;
    repeat (20) begin
      tick();
      if (evt.o_evt_valid) cnt_a++;
    end
    chk("t4_exactly_one", cnt_a, 0);

    // Reset mid-handshake
    raw = 5'b00011;
    wait_valid(20);
    chk("t5_code", evt.o_evt_code, DIR_UP);
    rst = 1'b1; raw = '0;
    tick();
    chk("t5_cleared", {level, press, evt.o_evt_valid, overflow}, 0);
    rst = 1'b0;
    cnt_a = 0;
    repeat (20) begin
      tick();
      if (evt.o_evt_valid) cnt_a++;
    end
    chk("t5_no_evt", cnt_a, 0);

    // Rst button
    raw[BTN_RST_IDX] = 1'b1;
    cnt_a = 0; cnt_b = 0;
    repeat (12) begin
      tick();
      if (press[BTN_RST_IDX]) cnt_a++;
      if (evt.o_evt_valid) cnt_b++;
    end
    chk("t6_press", cnt_a, 1);
    chk("t6_no_evt", cnt_b, 0);
    raw = '0;
    repeat (10) tick();

    // Randomized traffic
    repeat (400) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; ack = 1'b0; raw = '0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
